// File: rtl/snn_step_sequencer.sv
// -----------------------------------------------------------------------------
// snn_step_sequencer
//
// Multi-cycle controller for one inference-plus-learning step of a 2-input,
// 2-output shift-weight spiking layer pair. The layer-1 sums, the layer-1
// fire/shift products, the layer-2 sums, the weight update and the published
// result each get their own registered state.
//
// Sequence: IDLE -> SUM1 -> FIRE1 -> SUM2 -> [UPDATE if learn_en] -> DONE -> IDLE
//
// Optional build macro: SNN_REWARD_EN
//   Adds a 'reward' input, sampled in SUM2. With reward=0 the weight update
//   applies negated (anti-Hebbian) deltas. Without the macro the update rule
//   always applies positive reward.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request one step (sampled in IDLE, blocked by write_mode)
//   ui_in        input pair A, nibbles [7:4] and [3:0]
//   uio_in       input pair B, nibbles [7:4] and [3:0]
//   write_mode   configuration mode
//   wr_en        weight write strobe (IDLE and write_mode only)
//   wr_addr      0=w1(A->1) 1=w2(A->2) 2=w3(B->1) 3=w4(B->2)
//   wr_data      signed 5-bit weight value
//   learn_en     enables the UPDATE state (sampled in SUM2)
//   reward       (SNN_REWARD_EN only) reward polarity for the update
//   busy         high in every state except IDLE
//   done         one-cycle pulse while in DONE
//   prediction   registered result of the last step
//   spike        {outB, outA, preB, preA} of the last step, registered
//   weights      {w4, w3, w2, w1}
// -----------------------------------------------------------------------------
module snn_step_sequencer #(
    parameter logic [7:0] TH1  = 8'h01,
    parameter logic [7:0] TH2  = 8'h01,
    parameter int         WMAX = 15,
    parameter int         WMIN = -16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    input  logic        write_mode,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [4:0]  wr_data,
    input  logic        learn_en,
`ifdef SNN_REWARD_EN
    input  logic        reward,
`endif
    output logic        busy,
    output logic        done,
    output logic [7:0]  prediction,
    output logic [3:0]  spike,
    output logic [19:0] weights
);

    typedef enum logic [2:0] {
        S_IDLE, S_SUM1, S_FIRE1, S_SUM2, S_UPDATE, S_DONE
    } state_t;

    state_t state, next_state;

    logic [7:0]        a_q, b_q;           // latched input pairs
    logic [7:0]        s1_q, s2_q;         // layer-1 sums
    logic              pre_a_q, pre_b_q;   // layer-1 spikes
    logic [7:0]        n_q [4];            // shifted products, indexed like the weights
    logic [7:0]        t1_q, t2_q;         // layer-2 sums
    logic              out1_q, out2_q;     // layer-2 spikes
    logic signed [4:0] w_q [4];            // w1..w4
    logic              reward_eff;

    logic [7:0] s1_c, s2_c, t1_c, t2_c;

    // Signed shift: left for w>=0 (truncated to 8 bits), logical right for
    // w<0. The magnitude is taken in 6 bits so that w=-16 yields 16.
    function automatic logic [7:0] shift_w(input logic [7:0] x, input logic signed [4:0] w);
        logic [5:0] amt;
        if (!w[4]) amt = {1'b0, w};
        else       amt = 6'd0 - {w[4], w};
        if (amt >= 6'd8)  return 8'd0;
        else if (!w[4])   return x << amt[2:0];
        else              return x >> amt[2:0];
    endfunction

    // Reward-modulated step: co-active pre/post strengthens, a lone pre or
    // lone post spike weakens; negative reward flips the sign. Saturating.
    function automatic logic signed [4:0] learn_step(input logic signed [4:0] w,
                                                     input logic pre, input logic post,
                                                     input logic rew);
        int d;
        int v;
        d = 0;
        if (pre && post)      d = 1;
        else if (pre || post) d = -1;
        if (!rew) d = -d;
        v = int'(w) + d;
        if (v > WMAX)      v = WMAX;
        else if (v < WMIN) v = WMIN;
        return 5'(v);
    endfunction

    assign s1_c = {4'd0, a_q[7:4]} + {4'd0, a_q[3:0]};
    assign s2_c = {4'd0, b_q[7:4]} + {4'd0, b_q[3:0]};
    assign t1_c = n_q[0] + n_q[2];
    assign t2_c = n_q[1] + n_q[3];

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign weights = {w_q[3], w_q[2], w_q[1], w_q[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned
        // (which would infer a latch).
        next_state = state;
        unique case (state)
            S_IDLE:   if (start && !write_mode) next_state = S_SUM1;
            S_SUM1:   next_state = S_FIRE1;
            S_FIRE1:  next_state = S_SUM2;
            S_SUM2:   next_state = learn_en ? S_UPDATE : S_DONE;
            S_UPDATE: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

`ifdef SNN_REWARD_EN
    logic reward_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                reward_q <= 1'b0;
        else if (state == S_SUM2)  reward_q <= reward;
    end
    assign reward_eff = reward_q;
`else
    assign reward_eff = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            pre_a_q    <= 1'b0;
            pre_b_q    <= 1'b0;
            t1_q       <= '0;
            t2_q       <= '0;
            out1_q     <= 1'b0;
            out2_q     <= 1'b0;
            prediction <= '0;
            spike      <= '0;
            // NOTE: the weights are architectural state with a defined reset
            // value, so unlike a RAM this small array is reset.
            for (int i = 0; i < 4; i++) begin
                n_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    // write_mode blocks start, so a simultaneous write wins.
                    if (write_mode && wr_en) w_q[wr_addr] <= wr_data;
                    if (start && !write_mode) begin
                        a_q <= ui_in;
                        b_q <= uio_in;
                    end
                end
                S_SUM1: begin
                    s1_q    <= s1_c;
                    s2_q    <= s2_c;
                    pre_a_q <= (s1_c > TH1);
                    pre_b_q <= (s2_c > TH2);
                end
                S_FIRE1: begin
                    n_q[0] <= pre_a_q ? shift_w(s1_q, w_q[0]) : 8'd0;
                    n_q[1] <= pre_a_q ? shift_w(s1_q, w_q[1]) : 8'd0;
                    n_q[2] <= pre_b_q ? shift_w(s2_q, w_q[2]) : 8'd0;
                    n_q[3] <= pre_b_q ? shift_w(s2_q, w_q[3]) : 8'd0;
                end
                S_SUM2: begin
                    t1_q   <= t1_c;
                    t2_q   <= t2_c;
                    out1_q <= (t1_c > TH1);
                    out2_q <= (t2_c > TH2);
                end
                S_UPDATE: begin
                    // All four weights commit on this single edge.
                    w_q[0] <= learn_step(w_q[0], pre_a_q, out1_q, reward_eff);
                    w_q[1] <= learn_step(w_q[1], pre_a_q, out2_q, reward_eff);
                    w_q[2] <= learn_step(w_q[2], pre_b_q, out1_q, reward_eff);
                    w_q[3] <= learn_step(w_q[3], pre_b_q, out2_q, reward_eff);
                end
                S_DONE: begin
                    prediction <= (out1_q ? t1_q : 8'd0) + (out2_q ? t2_q : 8'd0);
                    spike      <= {out2_q, out1_q, pre_b_q, pre_a_q};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_step_sequencer
//
// Self-checking bench for snn_step_sequencer: directed scenarios plus random
// steps, compared against an arithmetic reference model of one step.
// -----------------------------------------------------------------------------
module tb_snn_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, write_mode, wr_en, learn_en, reward;
    logic [7:0]  ui_in, uio_in;
    logic [1:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        busy, done;
    logic [7:0]  prediction;
    logic [3:0]  spike;
    logic [19:0] weights;

    int n_checks = 0;
    int n_fail   = 0;
    int mw [4];          // model weights, signed ints -16..15

    always #5 clk = ~clk;

    snn_step_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .write_mode (write_mode),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .learn_en   (learn_en),
`ifdef SNN_REWARD_EN
        .reward     (reward),
`endif
        .busy       (busy),
        .done       (done),
        .prediction (prediction),
        .spike      (spike),
        .weights    (weights)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int shf(input int x, input int w);
        if (w >= 0) return (w >= 8) ? 0 : ((x << w) & 255);
        else        return (-w >= 8) ? 0 : (x >> (-w));
    endfunction

    function automatic logic [19:0] packw();
        logic [19:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = mw[i];
            r[i*5 +: 5] = v[4:0];
        end
        return r;
    endfunction

    task automatic model_step(input logic [7:0] ui, input logic [7:0] uio, input bit learn,
                              input bit rew, output int pred, output int spk);
        int s1, s2, t1, t2, d, pre, post;
        int n [4];
        bit pa, pb, o1, o2;
        s1 = ui[7:4] + ui[3:0];
        s2 = uio[7:4] + uio[3:0];
        pa = (s1 > 1);
        pb = (s2 > 1);
        n[0] = pa ? shf(s1, mw[0]) : 0;
        n[1] = pa ? shf(s1, mw[1]) : 0;
        n[2] = pb ? shf(s2, mw[2]) : 0;
        n[3] = pb ? shf(s2, mw[3]) : 0;
        t1 = (n[0] + n[2]) % 256;
        t2 = (n[1] + n[3]) % 256;
        o1 = (t1 > 1);
        o2 = (t2 > 1);
        pred = ((o1 ? t1 : 0) + (o2 ? t2 : 0)) % 256;
        spk  = {o2, o1, pb, pa};
        if (learn) begin
            for (int i = 0; i < 4; i++) begin
                pre  = (i < 2) ? pa : pb;
                post = (i % 2 == 0) ? o1 : o2;
                if (pre && post)      d = 1;
                else if (pre || post) d = -1;
                else                  d = 0;
                if (!rew) d = -d;
                mw[i] = mw[i] + d;
                if (mw[i] > 15)  mw[i] = 15;
                if (mw[i] < -16) mw[i] = -16;
            end
        end
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mw[i] = 0;
    endtask

    task automatic write_w(input int addr, input int data, input bit with_start);
        @(negedge clk);
        write_mode = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = addr[1:0];
        wr_data    = data[4:0];
        start      = with_start;
        @(negedge clk);
        write_mode = 1'b0;
        wr_en      = 1'b0;
        start      = 1'b0;
        mw[addr]   = data;
        check("write_no_busy", {31'd0, busy}, 0);
    endtask

    task automatic run_step(input logic [7:0] ui, input logic [7:0] uio, input bit learn,
                            input bit rew, input bit disturb);
        int cyc, ep, es;
        @(negedge clk);
        ui_in    = ui;
        uio_in   = uio;
        learn_en = learn;
        reward   = rew;
        start    = 1'b1;
        model_step(ui, uio, learn, rew, ep, es);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        check("busy_in_step", {31'd0, busy}, 1);
        if (disturb) begin
            ui_in      = 8'($urandom);
            uio_in     = 8'($urandom);
            write_mode = 1'b1;
            wr_en      = 1'b1;
            wr_addr    = 2'($urandom);
            wr_data    = 5'($urandom);
            start      = 1'b1;
        end
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        write_mode = 1'b0;
        wr_en      = 1'b0;
        start      = 1'b0;
        check("done_latency", cyc, learn ? 5 : 4);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 0);
        check("idle_after", {31'd0, busy}, 0);
        check("prediction", {24'd0, prediction}, ep);
        check("spike", {28'd0, spike}, es);
        check("weights", {12'd0, weights}, {12'd0, packw()});
    endtask

    function automatic bit rand_reward();
`ifdef SNN_REWARD_EN
        return bit'($urandom_range(1, 0));
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; write_mode = 1'b0; wr_en = 1'b0;
        learn_en = 1'b1; reward = 1'b1; ui_in = '0; uio_in = '0;
        wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 4; i++) mw[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_prediction", {24'd0, prediction}, 0);
        check("rst_spike", {28'd0, spike}, 0);
        check("rst_weights", {12'd0, weights}, 0);

        // Basic step, then repeat with the learned weights.
        run_step(8'h23, 8'h11, 1'b1, 1'b1, 1'b0);
        check("s1_prediction", {24'd0, prediction}, 14);
        check("s1_spike", {28'd0, spike}, 4'hF);
        check("s1_weights", {12'd0, weights}, 20'h08421);
        run_step(8'h23, 8'h11, 1'b1, 1'b1, 1'b0);
        check("s1b_prediction", {24'd0, prediction}, 28);
        check("s1b_weights", {12'd0, weights}, 20'h10842);

        // Reset in FIRE1 takes effect without waiting for an edge.
        @(negedge clk);
        ui_in = 8'h23; uio_in = 8'h11; learn_en = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;      // SUM1
        @(posedge clk); #1;                    // FIRE1
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_prediction", {24'd0, prediction}, 0);
        check("midrst_spike", {28'd0, spike}, 0);
        check("midrst_weights", {12'd0, weights}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mw[i] = 0;

        // No pre-synaptic spikes.
        run_step(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
        check("quiet_prediction", {24'd0, prediction}, 0);

        // Negative weight: right shift.
        write_w(0, -2, 1'b0);
        run_step(8'h44, 8'h00, 1'b1, 1'b1, 1'b0);
        check("neg_prediction", {24'd0, prediction}, 10);
        check("neg_weights", {12'd0, weights}, 20'hFFC3F);

        // Positive saturation (write arrives together with start: write wins).
        write_w(0, 15, 1'b1);
        write_w(2, 0, 1'b0);
        run_step(8'h23, 8'h11, 1'b1, 1'b1, 1'b0);
        check("sat_hi_w1", {27'd0, weights[4:0]}, 5'h0F);

        // Negative saturation: out1 fires through B while A stays quiet.
        write_w(0, -16, 1'b0);
        write_w(2, 0, 1'b0);
        run_step(8'h10, 8'h11, 1'b1, 1'b1, 1'b0);
        check("sat_lo_w1", {27'd0, weights[4:0]}, 5'h10);

        // learn_en=0, and writes/start/input changes while busy.
        run_step(8'h35, 8'h22, 1'b0, 1'b1, 1'b0);
        run_step(8'h35, 8'h22, 1'b1, 1'b1, 1'b1);

        // start under write_mode is ignored.
        @(negedge clk);
        start = 1'b1; write_mode = 1'b1;
        @(posedge clk); #1;
        check("start_in_write_mode", {31'd0, busy}, 0);
        @(negedge clk);
        start = 1'b0; write_mode = 1'b0;

`ifdef SNN_REWARD_EN
        do_reset();
        run_step(8'h23, 8'h11, 1'b1, 1'b0, 1'b0);
        check("antihebb_weights", {12'd0, weights}, 20'hFFFFF);
`endif

        // Random steps.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(3, 0) == 0)
                write_w(int'($urandom_range(3, 0)), int'($urandom_range(31, 0)) - 16, 1'b0);
            run_step(8'($urandom), 8'($urandom), bit'($urandom_range(1, 0)),
                     rand_reward(), bit'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
